// File: rtl/intan_frame_asm_pkg.sv
// intan_pkg: shared FSM state encoding, default frame markers and frame-length helper
package intan_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CNT, S_WAIT, S_RD, S_LAT, S_BYTE, S_TAIL, S_CHK, S_DONE
  } state_t;
  localparam logic [7:0] HEAD_DEF = 8'hAA;
  localparam logic [7:0] TAIL_DEF = 8'h55;
  function automatic int frame_len(input int nch, input int dw, input bit chk);
    return 3 + nch * dw / 8 + int'(chk);
  endfunction
endpackage

// File: rtl/intan_frame_asm_if.sv
// intan_frame_asm_if: byte-wide valid/ready uplink stream
// master drives tx_data/tx_valid and samples tx_ready; slave is the downstream sink
interface intan_frame_asm_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/intan_byte_tx.sv
// intan_byte_tx: registered tx_data/tx_valid output stage with handshake hold
// ports: clk, rst_n (sync active-low), load/byte_in (new byte from FSM),
//        accept (byte taken this cycle), tx (uplink master modport)
module intan_byte_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       accept,
  intan_frame_asm_if.master tx
);
  assign accept = tx.tx_valid & tx.tx_ready;
  // load is only issued when the stage is empty or being drained, so a stalled byte is never overwritten
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
    end else if (load) begin
      tx.tx_valid <= 1'b1;
      tx.tx_data  <= byte_in;
    end else if (accept) begin
      tx.tx_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/intan_frame_asm.sv
// intan_frame_asm: drains one sample per channel and serialises header, counter, samples, tail
// ports: clk, rst_n (sync active-low), start, fifo_empty/fifo_rden/fifo_rxd (per-channel FIFOs),
//        tx (uplink master modport), busy, frame_done, err_timeout (sticky)
// option: INTAN_FRAME_CHECKSUM_EN appends an XOR checksum byte after the tail
module intan_frame_asm
  import intan_pkg::*;
#(
  parameter int         NUM_CH  = 8,
  parameter int         DW      = 16,
  parameter logic [7:0] HEAD    = HEAD_DEF,
  parameter logic [7:0] TAIL    = TAIL_DEF,
  parameter int         TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    fifo_empty,
  output logic [NUM_CH-1:0]    fifo_rden,
  input  logic [NUM_CH*DW-1:0] fifo_rxd,
  intan_frame_asm_if.master    tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_timeout
);
  localparam int NB = DW / 8;
  localparam int KW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT);
`ifdef INTAN_FRAME_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif
  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic [BW-1:0]     bi_q;
  logic [TW-1:0]     tmo_q;
  logic [DW-1:0]     sh_q;
  logic [7:0]        cnt_q, chk_q, byte_in;
  logic [NUM_CH-1:0] rden_q;
  logic              issued_q, busy_q, done_q, err_q, load, accept, last_b, last_k;
  assign last_b      = bi_q == BW'(NB - 1);
  assign last_k      = k_q == KW'(NUM_CH - 1);
  assign fifo_rden   = rden_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign err_timeout = err_q;
  // issued_q marks that the current state's byte already sits in the output stage;
  // on accept the next byte is loaded in the same edge to keep one byte per cycle
  always_comb begin
    load = (!issued_q && (state_q == S_HDR || state_q == S_BYTE)) ||
           (accept && (state_q == S_HDR || (state_q == S_BYTE && (!last_b || last_k)) ||
                       (CHK_ON && state_q == S_TAIL)));
    byte_in = state_q == S_HDR ? (issued_q ? cnt_q : HEAD) :
              state_q == S_TAIL ? chk_q :
              (state_q == S_BYTE && issued_q && last_b) ? TAIL : sh_q[DW-1 -: 8];
  end
`ifdef INTAN_FRAME_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || state_q == S_IDLE) chk_q <= '0;
    else if (load) chk_q <= chk_q ^ byte_in;
  end
`else
  assign chk_q = '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      bi_q     <= '0;
      tmo_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      rden_q   <= '0;
      issued_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_HDR;
          k_q      <= '0;
          issued_q <= 1'b0;
          busy_q   <= 1'b1;
        end
        S_HDR: begin
          issued_q <= 1'b1;
          if (accept) state_q <= S_CNT;
        end
        S_CNT: if (accept) begin
          state_q  <= S_WAIT;
          issued_q <= 1'b0;
          tmo_q    <= '0;
        end
        S_WAIT: begin
          // checking empty first lets a late non-empty win over a simultaneous timeout
          if (!fifo_empty[k_q]) begin
            state_q <= S_RD;
            rden_q  <= NUM_CH'(1) << k_q;
            tmo_q   <= '0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_BYTE;
            sh_q    <= '0;
            bi_q    <= '0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RD: begin
          rden_q  <= '0;
          state_q <= S_LAT;
        end
        S_LAT: begin
          sh_q    <= fifo_rxd[32'(k_q) * DW +: DW];
          bi_q    <= '0;
          state_q <= S_BYTE;
        end
        S_BYTE: begin
          if (load) sh_q <= sh_q << 8;
          issued_q <= 1'b1;
          if (accept) begin
            bi_q <= last_b ? '0 : bi_q + BW'(1);
            if (last_b && last_k) state_q <= S_TAIL;
            else if (last_b) begin
              state_q  <= S_WAIT;
              k_q      <= k_q + KW'(1);
              issued_q <= 1'b0;
              tmo_q    <= '0;
            end
          end
        end
        S_TAIL: if (accept) begin
          state_q <= CHK_ON ? S_CHK : S_DONE;
          done_q  <= !CHK_ON;
        end
        S_CHK: if (accept) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          issued_q <= 1'b0;
          cnt_q    <= cnt_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  intan_byte_tx u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .byte_in (byte_in),
    .accept  (accept),
    .tx      (tx)
  );
endmodule
